// File: rtl/ws2812_pkg.sv
// Shared WS2812 line constants and receiver state encoding.
// Timing values are 50 MHz clock cycles and are shared with the ws2812 transmitter.
package ws2812_pkg;

    localparam int unsigned T0H_CYC       = 20;    // high time of a 0 bit
    localparam int unsigned T1H_CYC       = 40;    // high time of a 1 bit
    localparam int unsigned T0L_CYC       = 42;    // low time of a 0 bit
    localparam int unsigned T1L_CYC       = 22;    // low time of a 1 bit
    localparam int unsigned BIT_CYC       = 62;    // nominal bit period (1.25 us)
    localparam int unsigned RESET_LOW_CYC = 2500;  // latch low time (50 us)

    localparam int unsigned PIXEL_W       = 24;    // GRB pixel word

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous line, plus a delay flop for edge strobes.
// Ports:
//   clk, reset  : clock, async active-high reset
//   din         : asynchronous input
//   din_sync    : synchronized level (registered)
//   rise_c      : combinational strobe, synchronized rising edge
//   fall_c      : combinational strobe, synchronized falling edge
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_sync,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Pure shift chain: meta -> sync -> dly.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign din_sync = sync_q;
    assign rise_c   = sync_q & ~dly_q;
    assign fall_c   = ~sync_q & dly_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ line decoder: recovers 24-bit GRB pixels with their frame index,
// and flags frame latch (long low) and timing / overflow errors.
// Ports:
//   clk, reset   : clock, async active-high reset
//   din          : asynchronous WS2812 data line
//   pixel_data   : last decoded pixel, first-received bit at [23]
//   pixel_valid  : one-cycle strobe, pixel_data / pixel_index valid
//   pixel_index  : 0-based position of pixel_data in the frame
//   frame_done   : one-cycle strobe on latch
//   frame_count  : pixels received in the latched frame (valid with frame_done)
//   err          : one-cycle strobe on glitch, over-long high, overflow or partial pixel
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned BIT_THRESH = 30,
    parameter int unsigned MIN_HIGH   = 8,
    parameter int unsigned MAX_HIGH   = 60,
    parameter int unsigned RESET_LOW  = RESET_LOW_CYC,
    parameter int unsigned NUM_PIXELS = 64,
    parameter int unsigned IDX_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    output logic [IDX_W-1:0]   pixel_index,
    output logic               frame_done,
    output logic [IDX_W:0]     frame_count,
    output logic               err
);

    localparam int unsigned CNT_W  = $clog2(RESET_LOW + 1);
    localparam int unsigned BCNT_W = $clog2(PIXEL_W);
    localparam int unsigned PCNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_LOW);

    logic din_sync, rise_c, fall_c;

    sync_edge u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_sync (din_sync),
        .rise_c   (rise_c),
        .fall_c   (fall_c)
    );

    rx_state_e           state_q, state_d;
    logic [CNT_W-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0]    lcnt_q, lcnt_d;
    logic [PIXEL_W-2:0]  shift_q, shift_d;   // the 24th bit completes the word directly
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [PIXEL_W-1:0]  pixel_data_q, pixel_data_d;
    logic [IDX_W-1:0]    pixel_index_q, pixel_index_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [PCNT_W-1:0]   frame_count_q, frame_count_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]    hcnt_inc_c, lcnt_inc_c;
    logic                bit_val_c;

    // Saturating counter increments; counters never wrap.
    assign hcnt_inc_c = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);
    assign lcnt_inc_c = (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + CNT_W'(1);
    assign bit_val_c  = (hcnt_q >= CNT_W'(BIT_THRESH));

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        shift_d       = shift_q;
        bcnt_d        = bcnt_q;
        pcnt_d        = pcnt_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        err_d         = 1'b0;

        case (state_q)
            // Wait for one full latch-length low before trusting frame alignment.
            S_SYNC: begin
                if (din_sync) begin
                    lcnt_d = '0;
                end else if (lcnt_inc_c == CNT_MAX) begin
                    state_d = S_IDLE;
                    lcnt_d  = '0;
                    bcnt_d  = '0;
                    pcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_inc_c;
                end
            end

            S_IDLE: begin
                if (rise_c) begin
                    state_d = S_HIGH;
                    hcnt_d  = CNT_W'(1);
                end
            end

            S_HIGH: begin
                if (fall_c) begin
                    if (hcnt_q < CNT_W'(MIN_HIGH)) begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                        lcnt_d  = '0;
                        bcnt_d  = '0;
                        pcnt_d  = '0;
                    end else begin
                        state_d = S_LOW;
                        lcnt_d  = CNT_W'(1);
                        if (bcnt_q == BCNT_W'(PIXEL_W - 1)) begin
                            bcnt_d = '0;
                            if (pcnt_q < PCNT_W'(NUM_PIXELS)) begin
                                pixel_data_d  = {shift_q, bit_val_c};
                                pixel_index_d = pcnt_q[IDX_W-1:0];
                                pixel_valid_d = 1'b1;
                                pcnt_d        = pcnt_q + PCNT_W'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            shift_d = {shift_q[PIXEL_W-3:0], bit_val_c};
                            bcnt_d  = bcnt_q + BCNT_W'(1);
                        end
                    end
                end else if (hcnt_q >= CNT_W'(MAX_HIGH)) begin
                    // Still high after MAX_HIGH cycles: pulse is too long.
                    err_d   = 1'b1;
                    state_d = S_SYNC;
                    lcnt_d  = '0;
                    bcnt_d  = '0;
                    pcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_inc_c;
                end
            end

            S_LOW: begin
                if (rise_c) begin
                    state_d = S_HIGH;
                    hcnt_d  = CNT_W'(1);
                end else begin
                    lcnt_d = lcnt_inc_c;
                    if (lcnt_inc_c == CNT_MAX) begin
                        // Latch: report the frame, flag any partial pixel.
                        frame_done_d  = 1'b1;
                        frame_count_d = pcnt_q;
                        err_d         = (bcnt_q != '0);
                        pcnt_d        = '0;
                        bcnt_d        = '0;
                        lcnt_d        = '0;
                        state_d       = S_IDLE;
                    end
                end
            end

            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_SYNC;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            shift_q       <= '0;
            bcnt_q        <= '0;
            pcnt_q        <= '0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            shift_q       <= shift_d;
            bcnt_q        <= bcnt_d;
            pcnt_q        <= pcnt_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_index = pixel_index_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx. A bit-level model predicts the ordered list of
// output strobes (pixel / error / frame) from the waveform the bench drives; a compare
// process matches every observed strobe against that list.
module tb_ws2812_rx;

    localparam int NPIX  = 64;
    localparam int RL    = 2500;
    localparam int MINH  = 8;
    localparam int MAXH  = 60;
    localparam int THR   = 30;
    localparam int GAP   = RL + 20;

    localparam logic [2:0] ST_PIX = 3'b100;
    localparam logic [2:0] ST_ERR = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [5:0]  pixel_index;
    logic        frame_done;
    logic [6:0]  frame_count;
    logic        err;

    ws2812_rx dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  strobes;  // {pixel_valid, frame_done, err}
        logic [23:0] data;
        int          idx;
        int          cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur;

    int checks = 0;
    int errors = 0;

    // Model state.
    bit          aligned = 1'b0;
    int          bits    = 0;
    int          pcount  = 0;
    logic [23:0] acc     = '0;
    int          fall_cyc = 0;

    // Observations of the DUT for hand-computed spot checks.
    int          n_pix = 0;
    int          n_err = 0;
    int          n_frame = 0;
    logic [23:0] last_data = '0;
    int          last_idx = 0;
    int          last_fcount = 0;
    logic        last_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic [2:0] s, input logic [23:0] d, input int idx, input int cnt);
        ev_t e;
        e.strobes = s;
        e.data    = d;
        e.idx     = idx;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endfunction

    // Bit-level decode rules.
    function automatic void model_bit(input int hi);
        if (!aligned) return;
        if (hi < MINH || hi > MAXH) begin
            push(ST_ERR, '0, 0, 0);
            aligned = 1'b0;
            bits    = 0;
            pcount  = 0;
            return;
        end
        acc  = {acc[22:0], (hi >= THR)};
        bits = bits + 1;
        if (bits == 24) begin
            if (pcount < NPIX) begin
                push(ST_PIX, acc, pcount, 0);
                pcount = pcount + 1;
            end else begin
                push(ST_ERR, '0, 0, 0);
            end
            bits = 0;
        end
    endfunction

    // A latch-length low: ends a frame when aligned, otherwise establishes alignment.
    function automatic void model_gap();
        if (aligned) push({1'b0, 1'b1, (bits != 0)}, '0, 0, pcount);
        aligned = 1'b1;
        bits    = 0;
        pcount  = 0;
    endfunction

    // All drive tasks start and end just after a falling clock edge.
    task automatic send_bit(input int hi, input int lo);
        model_bit(hi);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_gap();
        model_gap();
        din = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    // mode 0: nominal timing, 1: fastest legal, 2: jittered, 3: threshold boundaries
    task automatic send_pixel(input logic [23:0] d, input int mode);
        logic b;
        int   hi, lo;
        for (int i = 23; i >= 0; i--) begin
            b = d[i];
            case (mode)
                0: begin hi = b ? 40 : 20; lo = b ? 22 : 42; end
                1: begin hi = b ? THR : MINH; lo = 1; end
                2: begin hi = b ? THR + $urandom_range(0, 1) : MINH + $urandom_range(0, 1); lo = 1; end
                default: begin hi = b ? ((i % 2) ? MAXH : THR) : ((i % 2) ? THR - 1 : MINH); lo = 5; end
            endcase
            send_bit(hi, lo);
        end
    endtask

    // Compare every strobe cycle against the next predicted event.
    always @(negedge clk) begin
        if (!reset && (pixel_valid || frame_done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: pv=%0b fd=%0b err=%0b, none expected (cycle %0d)",
                         pixel_valid, frame_done, err, cyc);
            end else begin
                cur = exp_q.pop_front();
                check("strobes", {29'd0, pixel_valid, frame_done, err}, {29'd0, cur.strobes});
                if (cur.strobes == ST_PIX) begin
                    check("pixel_data", {8'd0, pixel_data}, {8'd0, cur.data});
                    check("pixel_index", 32'(pixel_index), 32'(cur.idx));
                    check("pixel_latency", 32'(cyc - fall_cyc), 32'd3);
                end
                if (cur.strobes[1]) check("frame_count", 32'(frame_count), 32'(cur.cnt));
            end
            if (pixel_valid) begin
                n_pix++;
                last_data = pixel_data;
                last_idx  = 32'(pixel_index);
            end
            if (err) n_err++;
            if (frame_done) begin
                n_frame++;
                last_fcount = 32'(frame_count);
                last_ferr   = err;
            end
        end
    end

    int p0, e0;

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {1'b0, pixel_data, pixel_valid, pixel_index, frame_done}, 32'd0);
        check("reset_outputs2", {24'd0, frame_count, err}, 32'd0);
        reset = 1'b0;

        // 1: single pixel with nominal timing
        send_gap();
        send_pixel(24'hA50FF0, 0);
        send_gap();
        check("t1_npix", 32'(n_pix), 32'd1);
        check("t1_data", {8'd0, last_data}, 32'h00A50FF0);
        check("t1_idx", 32'(last_idx), 32'd0);
        check("t1_fcount", 32'(last_fcount), 32'd1);
        check("t1_noerr", 32'(n_err), 32'd0);

        // 2: full frame of 64 patterned pixels
        p0 = n_pix;
        for (int i = 0; i < NPIX; i++) begin
            logic [7:0] v;
            v = 8'(i);
            send_pixel({v, ~v, v}, 1);
        end
        send_gap();
        check("t2_npix", 32'(n_pix - p0), 32'd64);
        check("t2_last_data", {8'd0, last_data}, 32'h003FC03F);
        check("t2_last_idx", 32'(last_idx), 32'd63);
        check("t2_fcount", 32'(last_fcount), 32'd64);

        // 3: overflow with 65 random pixels
        p0 = n_pix;
        e0 = n_err;
        for (int i = 0; i < NPIX + 1; i++) send_pixel(24'($urandom()), 2);
        send_gap();
        check("t3_npix", 32'(n_pix - p0), 32'd64);
        check("t3_err", 32'(n_err - e0), 32'd1);
        check("t3_fcount", 32'(last_fcount), 32'd64);

        // 4: partial pixel then latch
        for (int i = 0; i < 10; i++) send_bit($urandom_range(0, 1) ? THR : MINH, 3);
        send_gap();
        check("t4_fcount", 32'(last_fcount), 32'd0);
        check("t4_frame_err", 32'(last_ferr), 32'd1);

        // 5: short glitch mid-pixel, resync, then a boundary-timed pixel
        e0 = n_err;
        for (int i = 0; i < 7; i++) send_bit(THR, 5);
        send_bit(4, 10);
        for (int i = 0; i < 16; i++) send_bit(($urandom_range(0, 1) != 0) ? THR : MINH, 5);
        send_gap();
        send_pixel(24'h3C5A96, 3);
        send_gap();
        check("t5_err", 32'(n_err - e0), 32'd1);
        check("t5_data", {8'd0, last_data}, 32'h003C5A96);
        check("t5_idx", 32'(last_idx), 32'd0);
        check("t5_fcount", 32'(last_fcount), 32'd1);

        // 6: over-long high, then reset mid-pixel with the line toggling across release
        e0 = n_err;
        p0 = n_pix;
        send_bit(75, 10);
        for (int i = 0; i < 5; i++) send_bit(THR, 5);
        din = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        aligned = 1'b0;
        bits = 0;
        pcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) reset = 1'b0;
            din = ~din;
            repeat (3) @(negedge clk);
        end
        din = 1'b0;
        check("t6_no_pix_before_sync", 32'(n_pix - p0), 32'd0);
        send_gap();
        send_pixel(24'h5AC3E1, 2);
        send_gap();
        check("t6_err", 32'(n_err - e0), 32'd1);
        check("t6_npix", 32'(n_pix - p0), 32'd1);
        check("t6_data", {8'd0, last_data}, 32'h005AC3E1);
        check("t6_idx", 32'(last_idx), 32'd0);
        check("t6_fcount", 32'(last_fcount), 32'd1);

        repeat (20) @(negedge clk);
        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- One-wire WS2812 NRZ decoder: the receive end of the LED data line driven by the ws2812 transmitter.
- Recovers 24-bit GRB pixel words, tags each with its index within the frame, and flags frame latch (reset-low) and timing errors.
- Used as an on-chip loopback checker and bench monitor: the LED data output is fed back into din, and decoded pixels are compared against the physics matrix.
- Streaming only; no storage beyond one pixel shift register.

Parameters:
- BIT_THRESH, 30: high-time cycles at or above which a bit decodes as 1 (50 MHz: T0H=20, T1H=40).
- MIN_HIGH, 8: high pulses shorter than this are glitches (error).
- MAX_HIGH, 60: high pulses longer than this are errors.
- RESET_LOW, 2500: low-time cycles (50 us) that constitute a latch / frame end.
- NUM_PIXELS, 64: pixels expected per frame (8x8 matrix).
- IDX_W, 6: width of pixel_index, equal to clog2(NUM_PIXELS).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- din, input, 1: serial WS2812 line, asynchronous to clk.
- pixel_data, output, 24: last decoded pixel, GRB, first-received bit at [23].
- pixel_valid, output, 1: one-cycle strobe; pixel_data and pixel_index are valid.
- pixel_index, output, IDX_W: position of pixel_data in the current frame, 0-based.
- frame_done, output, 1: one-cycle strobe on latch detection.
- frame_count, output, IDX_W+1: pixels received in the frame just latched; valid with frame_done.
- err, output, 1: one-cycle strobe on any timing or overflow error.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in SYNC; shift register, bit count, pixel count, high/low counters all 0.
  - Synchronizer flops 0.
- Input path:
  - 2-flop synchronizer plus one delay flop for edge detect.
  - All outputs are registered.
  - pixel_valid rises exactly 3 clk after the pin-level falling edge that ends bit 23 (2 sync + 1 output register).
- FSM states:
  - SYNC:
    - Count consecutive low cycles; any high clears the count.
    - On count reaching RESET_LOW, go to IDLE. No frame_done is emitted.
    - Guarantees alignment after reset, including reset asserted mid-frame.
  - IDLE: line low and frame boundary known. Rising edge goes to HIGH with hcnt=1.
  - HIGH:
    - hcnt increments each cycle.
    - If hcnt exceeds MAX_HIGH: err pulse, discard partial pixel, go to SYNC.
    - On falling edge:
      - hcnt < MIN_HIGH: err pulse, go to SYNC.
      - Otherwise shift in bit = (hcnt >= BIT_THRESH), increment bit count, go to LOW with lcnt=1.
  - LOW:
    - lcnt increments, saturating at RESET_LOW.
    - Rising edge before RESET_LOW goes to HIGH with hcnt=1.
    - lcnt == RESET_LOW triggers latch, then go to IDLE.
- Pixel completion (24th bit shifted):
  - If pixel count < NUM_PIXELS:
    - pixel_data = shift value, pixel_index = pixel count, pixel_valid = 1.
    - Pixel count increments.
  - Else: err pulse, no pixel_valid, pixel count saturates at NUM_PIXELS.
  - Bit count resets to 0.
- Latch:
  - frame_done = 1 and frame_count = pixel count.
  - If bit count != 0 (partial pixel), err pulses in the same cycle.
  - Pixel count and bit count clear.
  - A latch with zero pixels still pulses frame_done, with frame_count=0.
- Simultaneous events: pixel completion and latch cannot coincide, because latch requires RESET_LOW low cycles after the last edge.
- Counter widths: hcnt and lcnt are clog2(RESET_LOW+1) bits and saturate; they never wrap.
- reset mid-operation: immediate asynchronous return to reset state; decoding resumes only after a full RESET_LOW low period.

Decomposition:
- Shared package ws2812_pkg:
  - Timing constants (T0H, T1H, bit period, RESET_LOW at 50 MHz), shared with the ws2812 transmitter.
  - FSM state enum {SYNC, IDLE, HIGH, LOW}.
  - GRB pixel width constant (24).
- One natural sub-module, sync_edge: 2-flop synchronizer plus rise/fall strobes.
- Everything else stays in ws2812_rx.

Test Plan:
1. Reset, hold din low 2500 cycles, send one pixel 0xA5_0F_F0 (1 = 40H/22L, 0 = 20H/42L), then 2500 low → pixel_valid once with pixel_data=0xA50FF0 and pixel_index=0; frame_done with frame_count=1; err never asserted.
2. After sync, send 64 pixels with pixel i = {i,~i,i} (8 bits each), then latch → 64 strobes with indices 0..63 and correct data; frame_done with frame_count=64.
3. Send 65 pixels → 64 pixel_valid; err on the 65th completion; frame_count=64.
4. Send 10 bits, then 2500 low → no pixel_valid; frame_done with frame_count=0; err in the same cycle.
5. Insert a 4-cycle high glitch mid-pixel → err; subsequent bits ignored until 2500 low; next clean pixel decodes correctly.
6. Assert reset mid-pixel, release while din is toggling → no pixel_valid until a 2500-cycle low is seen; the following pixel decodes at index 0.
